// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory request arbiter.
// The FSM state and operation encodings live here so the top level and any
// future requester-side logic agree on them.
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } req_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } req_op_t;

  localparam int MAX_NREQ = 8;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The request vector is rotated so that position 0 is the requester at ptr,
// the lowest set bit is isolated, and the result is rotated back. The caller
// owns the pointer register and must keep ptr below N.
module rr_arbiter
  import mem_req_pkg::*;
#(
  parameter int N = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     first_rot;
  logic [2*N-1:0]   gnt_dbl;
  logic [IDX_W-1:0] idx_acc [N+1];

  // Rotate right by ptr, isolate the first requester, rotate back left.
  assign req_dbl   = {req, req} >> ptr;
  assign req_rot   = req_dbl[N-1:0];
  assign first_rot = req_rot & (~req_rot + 1'b1);
  assign gnt_dbl   = {first_rot, first_rot} << ptr;
  assign gnt       = gnt_dbl[2*N-1:N];
  assign any_req   = |req;

  // One-hot to binary encoding of the grant.
  assign idx_acc[0] = '0;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_enc
      assign idx_acc[gi+1] = idx_acc[gi] | (gnt[gi] ? IDX_W'(gi) : '0);
    end
  endgenerate
  assign gnt_idx = idx_acc[N];

endmodule

// File: rtl/mem_request_arbiter.sv
// Memory request arbiter: NREQ requesters share one memory port with a single
// transaction in flight. A granted request is held in the mem_* registers
// until mem_ready, which produces a one-cycle hit to the granted requester.
// halt drains the in-flight transaction and parks the block until nRST.
// Optional feature: define REQ_TIMEOUT_EN to abandon a transaction after
// 2**TO_W-1 BUSY cycles without mem_ready (sticky timeout_err, request re-arbitrated).
module mem_request_arbiter
  import mem_req_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_W   = 8
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     halt,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_hit,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     mem_ren,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     halted,
  output logic                     timeout_err
);

  localparam int IDX_W = idx_width(NREQ);

  req_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  gnt_idx_reg, gnt_idx_next;
  logic              mem_ren_reg, mem_ren_next;
  logic              mem_wen_reg, mem_wen_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              halt_seen_reg, halt_seen_next;

  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  req_op_t           arb_op;
  logic              hit_fire;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

`ifdef REQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - 1'b1;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              timeout_err_reg, timeout_err_next;
`else
  logic              unused_cfg;
  assign unused_cfg = (TO_W == 0);
`endif

  // Unpack the flat per-requester buses so the winner can be selected by index.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign arb_req = req_ren | req_wen;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (arb_req),
    .ptr     (ptr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  // A write request masks a simultaneous read from the same requester.
  assign arb_op = req_wen[arb_idx] ? OP_WRITE : OP_READ;

  // Next-state and datapath decisions; registers hold by default.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gnt_idx_next   = gnt_idx_reg;
    mem_ren_next   = mem_ren_reg;
    mem_wen_next   = mem_wen_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    halt_seen_next = halt_seen_reg;
`ifdef REQ_TIMEOUT_EN
    to_cnt_next      = to_cnt_reg;
    timeout_err_next = timeout_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (halt) begin
          state_next = HALTED;
        end else if (arb_any) begin
          state_next     = BUSY;
          gnt_idx_next   = arb_idx;
          ptr_next       = (arb_idx == IDX_W'(NREQ-1)) ? '0 : arb_idx + 1'b1;
          mem_ren_next   = (arb_op == OP_READ);
          mem_wen_next   = (arb_op == OP_WRITE);
          mem_addr_next  = addr_arr[arb_idx];
          mem_wdata_next = wdata_arr[arb_idx];
          halt_seen_next = 1'b0;
`ifdef REQ_TIMEOUT_EN
          to_cnt_next    = '0;
`endif
        end
      end
      BUSY: begin
        halt_seen_next = halt_seen_reg | halt;
        if (mem_ready) begin
          state_next   = (halt_seen_reg | halt) ? HALTED : IDLE;
          mem_ren_next = 1'b0;
          mem_wen_next = 1'b0;
        end
`ifdef REQ_TIMEOUT_EN
        else if (to_cnt_reg == TO_LAST) begin
          state_next       = IDLE;
          mem_ren_next     = 1'b0;
          mem_wen_next     = 1'b0;
          timeout_err_next = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
`endif
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant bookkeeping and the registered memory-side request.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_reg       <= '0;
      gnt_idx_reg   <= '0;
      mem_ren_reg   <= 1'b0;
      mem_wen_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      halt_seen_reg <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      gnt_idx_reg   <= gnt_idx_next;
      mem_ren_reg   <= mem_ren_next;
      mem_wen_reg   <= mem_wen_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      halt_seen_reg <= halt_seen_next;
    end
  end

`ifdef REQ_TIMEOUT_EN
  // Timeout counter and its sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      to_cnt_reg      <= to_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  // Completion is only recognised while a transaction is in flight.
  assign hit_fire = (state_reg == BUSY) && mem_ready;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_hit
      assign req_hit[gi] = hit_fire && (gnt_idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign req_rdata = hit_fire ? mem_rdata : '0;
  assign mem_ren   = mem_ren_reg;
  assign mem_wen   = mem_wen_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg == BUSY);
  assign halted    = (state_reg == HALTED);

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter (NREQ=2, TO_W=4).
// A transaction-level model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_mem_request_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TOW  = 4;
  localparam int TO_LIMIT = (1 << TOW) - 1;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            halt = 1'b0;
  logic [NREQ-1:0] req_ren = '0;
  logic [NREQ-1:0] req_wen = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0] req_hit;
  logic [DW-1:0]   req_rdata;
  logic            mem_ren, mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_ready = 1'b0;
  logic            busy, halted, timeout_err;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;
  int cyc_n = 0;
  int hit_q[$];
  int hit_cyc_q[$];

  mem_request_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TO_W(TOW)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_hit(req_hit), .req_rdata(req_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .halted(halted), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  bit        m_busy, m_halted, m_wr, m_hseen, m_err;
  int        m_g, m_ptr, m_cnt;
  bit [31:0] m_addr, m_wdata;

  always @(posedge CLK or negedge nRST) begin
    int g;
    int c;
    if (!nRST) begin
      m_busy <= 0; m_halted <= 0; m_wr <= 0; m_hseen <= 0; m_err <= 0;
      m_g <= 0; m_ptr <= 0; m_cnt <= 0; m_addr <= 0; m_wdata <= 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy   <= 0;
        m_halted <= m_hseen | halt;
      end else begin
        m_hseen <= m_hseen | halt;
`ifdef REQ_TIMEOUT_EN
        if (m_cnt + 1 == TO_LIMIT) begin
          m_busy <= 0;
          m_err  <= 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
`endif
      end
    end else if (!m_halted) begin
      if (halt) begin
        m_halted <= 1;
      end else begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (g < 0 && (req_ren[c] || req_wen[c])) g = c;
        end
        if (g >= 0) begin
          m_busy  <= 1;
          m_g     <= g;
          m_ptr   <= (g + 1) % NREQ;
          m_wr    <= req_wen[g];
          m_addr  <= req_addr[g*AW +: AW];
          m_wdata <= req_wdata[g*DW +: DW];
          m_hseen <= 0;
          m_cnt   <= 0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge CLK) begin
    logic [NREQ-1:0] exp_hit;
    if (run_cmp) begin
      exp_hit = (m_busy && mem_ready) ? NREQ'(1 << m_g) : '0;
      chk("busy", busy, m_busy);
      chk("halted", halted, m_halted);
      chk("mem_ren", mem_ren, m_busy && !m_wr);
      chk("mem_wen", mem_wen, m_busy && m_wr);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("req_hit", req_hit, exp_hit);
      chk("req_rdata", req_rdata, (exp_hit != 0) ? mem_rdata : '0);
      chk("timeout_err", timeout_err, m_err);
      for (int i = 0; i < NREQ; i++) begin
        if (req_hit[i]) begin
          hit_q.push_back(i);
          hit_cyc_q.push_back(cyc_n);
        end
      end
    end
  end

  task automatic do_reset();
    nRST = 1'b0; halt = 1'b0; req_ren = '0; req_wen = '0; mem_ready = 1'b0;
    cyc(2);
    nRST = 1'b1;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    do_reset();
    run_cmp = 1'b1;
    chk("rst_ren", mem_ren, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);

    // single read, ready three cycles after the strobe
    req_addr[0 +: AW] = 32'h100;
    req_ren = 2'b01;
    cyc(1);
    chk("t1_ren", mem_ren, 1);
    chk("t1_wen", mem_wen, 0);
    chk("t1_addr", mem_addr, 32'h100);
    $display("txn read r0 addr=%0h strobe", mem_addr);
    cyc(2);
    mem_rdata = 32'h1234_5678;
    mem_ready = 1'b1;
    #3;
    chk("t1_hit", req_hit, 2'b01);
    chk("t1_rdata", req_rdata, 32'h1234_5678);
    $display("txn read r0 hit rdata=%0h", req_rdata);
    cyc(1);
    chk("t1_ren_drop", mem_ren, 0);
    req_ren = '0; mem_ready = 1'b0;
    cyc(2);

    // both requesters continuously, ready immediately
    do_reset();
    hit_q.delete(); hit_cyc_q.delete();
    req_addr[AW +: AW] = 32'h180;
    req_ren = 2'b11;
    mem_ready = 1'b1;
    cyc(8);
    req_ren = '0; mem_ready = 1'b0;
    chk("rr_count", hit_q.size(), 4);
    if (hit_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_order", hit_q[i], i % 2);
        $display("txn rr hit r%0d cycle=%0d", hit_q[i], hit_cyc_q[i]);
      end
      for (int i = 0; i < 3; i++) chk("rr_gap", hit_cyc_q[i+1] - hit_cyc_q[i], 2);
    end
    cyc(2);

    // requester 1 raises ren and wen: write wins
    do_reset();
    req_addr[AW +: AW] = 32'h200;
    req_wdata[DW +: DW] = 32'hDEAD_BEEF;
    req_ren = 2'b10; req_wen = 2'b10;
    cyc(1);
    chk("t3_wen", mem_wen, 1);
    chk("t3_ren", mem_ren, 0);
    chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    $display("txn write r1 addr=%0h wdata=%0h", mem_addr, mem_wdata);
    mem_ready = 1'b1;
    #3;
    chk("t3_hit", req_hit, 2'b10);
    cyc(1);
    req_ren = '0; req_wen = '0; mem_ready = 1'b0;
    cyc(2);

    // halt during BUSY drains then parks
    do_reset();
    req_addr[0 +: AW] = 32'h300;
    req_ren = 2'b01;
    cyc(1);
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    cyc(1);
    chk("t4_busy", busy, 1);
    mem_ready = 1'b1;
    #3;
    chk("t4_hit", req_hit, 2'b01);
    cyc(1);
    req_ren = '0; mem_ready = 1'b0;
    chk("t4_halted", halted, 1);
    $display("txn halt drain r0 halted=%0d", halted);
    req_ren = 2'b10;
    cyc(3);
    mem_ready = 1'b1;
    #3;
    chk("t4_no_hit", req_hit, 0);
    chk("t4_no_strobe", mem_ren, 0);
    cyc(1);
    req_ren = '0; mem_ready = 1'b0;

    // async reset mid-transaction, pointer returns to requester 0
    do_reset();
    req_addr[0 +: AW] = 32'h500;
    req_ren = 2'b01;
    cyc(1);
    chk("t5_busy", busy, 1);
    mem_ready = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk("t5_rst_ren", mem_ren, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_hit", req_hit, 0);
    chk("t5_rst_addr", mem_addr, 0);
    $display("txn reset abort busy=%0d hit=%0b", busy, req_hit);
    req_ren = 2'b11;
    cyc(1);
    nRST = 1'b1;
    cyc(1);
    #3;
    chk("t5_regrant", req_hit, 2'b01);
    cyc(1);
    req_ren = '0; mem_ready = 1'b0;
    cyc(1);

    // long stall: timeout when enabled, indefinite wait otherwise
    do_reset();
    req_addr[0 +: AW] = 32'h600;
    req_ren = 2'b01;
    cyc(1);
`ifdef REQ_TIMEOUT_EN
    cyc(14);
    chk("t6_still_busy", mem_ren, 1);
    cyc(1);
    chk("t6_drop", mem_ren, 0);
    chk("t6_err", timeout_err, 1);
    cyc(1);
    chk("t6_reissue", mem_ren, 1);
    $display("txn timeout r0 err=%0d reissued=%0d", timeout_err, mem_ren);
`else
    cyc(20);
    chk("t6_wait", mem_ren, 1);
    chk("t6_no_err", timeout_err, 0);
    $display("txn stall r0 still waiting ren=%0d", mem_ren);
`endif
    mem_ready = 1'b1;
    #3;
    chk("t6_hit", req_hit, 2'b01);
    cyc(1);
    req_ren = '0; mem_ready = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
